conv_layer_mc: RTL and testbench
================================

CONV_LAYER_MC -- requirements
Module: conv_layer_mc

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- I_SIZE, 28, input feature-map height and width.
- K_SIZE, 5, square kernel size.
- CI, 1, input channel count.
- CO, 4, output channel count.
- I_BW, 8, signed input sample width.
- W_BW, 8, signed weight width.
- ACC_BW, 20, signed accumulator width.
- O_BW, 16, output width.
- SHIFT, 4, right shift applied before output; SHIFT+O_BW <= ACC_BW.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, the single clock; all logic on its rising edge.
- global_rst_n, in, 1, asynchronous active-low reset.
- rst_processEnd, in, 1, synchronous clear to IDLE.
- i_valid, in, 1, input sample valid.
- o_ready, out, 1, block accepts input samples.
- i_fmap, in, I_BW, signed input sample.
- i_weight, in, CI*CO*K_SIZE*K_SIZE*W_BW, flattened signed weights; held stable by the source outside IDLE.
- o_result, out, O_BW, output pixel.
- o_valid, out, 1, one-cycle strobe per output pixel.
- o_ch_end, out, 1, strobe with the last pixel of each output channel.
- o_allch_end, out, 1, strobe with the last pixel of the last channel.
- o_busy, out, 1, high in every state except IDLE.

Function
REQ-003 O_SIZE = I_SIZE-K_SIZE+1; stride 1; no padding.
REQ-004 Internal single-port memory, depth CI*I_SIZE*I_SIZE, 1-cycle read latency; it is not cleared by reset.
REQ-005 FSM states: IDLE, LOAD, CALC, DONE.
- IDLE->LOAD on the first accepted sample.
- LOAD->CALC after sample CI*I_SIZE*I_SIZE-1 is accepted.
- CALC->DONE after the final pixel is strobed.
- DONE->IDLE after one cycle.
REQ-006 o_ready=1 in IDLE and LOAD only; a sample is accepted when i_valid&&o_ready. Gaps in i_valid stall loading without loss.
REQ-007 Load order: channel-major, then row, then column; address = (ci*I_SIZE+r)*I_SIZE+c.
REQ-008 Weight index = ((co*CI+ci)*K_SIZE+kr)*K_SIZE+kc, stored at bits [index*W_BW +: W_BW].
REQ-009 CALC order: co outermost, then output row, then output column. Each pixel takes CI*K_SIZE*K_SIZE MAC cycles (ci, kr, kc nested, kc fastest) plus 2 pipeline cycles. The pixel period is fixed at CI*K_SIZE*K_SIZE+2 cycles.
REQ-010 Each product is I_BW+W_BW bits signed, sign-extended into an ACC_BW accumulator. Accumulation wraps modulo 2^ACC_BW. The accumulator is cleared at the start of each pixel.
REQ-011 ReLU: a negative accumulator value becomes 0.
REQ-012 o_valid pulses one cycle per pixel, exactly CO*O_SIZE*O_SIZE pulses per frame. o_result holds its value until the next pulse.
REQ-013 o_ch_end and o_allch_end are coincident with the corresponding o_valid pulse. On the final pixel, all three strobes assert together.
REQ-014 i_valid is ignored in CALC and DONE. A new frame may begin loading the cycle after DONE.

Reset
REQ-015 When global_rst_n=0 (asynchronous):
- state=IDLE and all counters=0.
- o_result=0, o_valid=0, o_ch_end=0, o_allch_end=0, o_busy=0.
- o_ready=1 after release.
REQ-016 rst_processEnd=1 on a clock edge has the same effect synchronously in any state, including mid-LOAD and mid-CALC. The partial frame is discarded and no further strobes occur. rst_processEnd takes priority over a simultaneous i_valid.

Configuration
REQ-017 Macro CONV_LAYER_MC_SAT_EN.
- Defined: o_result = min(relu >> SHIFT, 2^(O_BW-1)-1).
- Undefined: o_result = relu[SHIFT +: O_BW]; plain bit-slice that wraps on overflow.

Verification
REQ-018 Common setup: I_SIZE=4, K_SIZE=3, CI=2, CO=2, SHIFT=0, O_BW=16.
- Stimulus: all inputs=1, all weights=1.
- Required: 8 o_valid pulses, each o_result=18.
- Required: o_ch_end on pulses 4 and 8; o_allch_end on pulse 8 only.
REQ-019 Same setup with co=1 weights all -1.
- Required: pulses 1-4 = 18, pulses 5-8 = 0 (ReLU).
REQ-020 Same setup with O_BW=4.
- With CONV_LAYER_MC_SAT_EN: every o_result=7.
- Without CONV_LAYER_MC_SAT_EN: every o_result=2.
REQ-021 Toggle i_valid 1/0 every cycle during LOAD.
- Required: identical results to REQ-018.
- Required: exactly 32 samples accepted; o_ready=0 from the cycle after the 32nd acceptance.
REQ-022 Assert rst_processEnd during the 3rd pixel of CALC.
- Required: next cycle o_valid=0, o_busy=0, o_ready=1.
- Required: a reloaded frame then reproduces REQ-018 exactly.
REQ-023 Timing check under the REQ-018 setup.
- Required: pulse spacing is exactly 20 cycles.
- Required: global_rst_n low mid-CALC clears all outputs within the same cycle (asynchronously).

Source files
------------

// File: rtl/conv_layer_mc.sv
// Multi-channel 2-D convolution layer: buffers one frame, then streams ReLU'd output pixels.
// Optional macro CONV_LAYER_MC_SAT_EN: saturate the output instead of bit-slicing it.
module conv_layer_mc #(
  parameter int unsigned I_SIZE = 28,
  parameter int unsigned K_SIZE = 5,
  parameter int unsigned CI     = 1,
  parameter int unsigned CO     = 4,
  parameter int unsigned I_BW   = 8,
  parameter int unsigned W_BW   = 8,
  parameter int unsigned ACC_BW = 20,
  parameter int unsigned O_BW   = 16,
  parameter int unsigned SHIFT  = 4
) (
  input  logic                                  clk,
  input  logic                                  global_rst_n,
  input  logic                                  rst_processEnd,
  input  logic                                  i_valid,
  output logic                                  o_ready,
  input  logic [I_BW-1:0]                       i_fmap,
  input  logic [CI*CO*K_SIZE*K_SIZE*W_BW-1:0]   i_weight,
  output logic [O_BW-1:0]                       o_result,
  output logic                                  o_valid,
  output logic                                  o_ch_end,
  output logic                                  o_allch_end,
  output logic                                  o_busy
);

  localparam int unsigned O_SIZE = I_SIZE - K_SIZE + 1;
  localparam int unsigned DEPTH  = CI * I_SIZE * I_SIZE;
  localparam int unsigned NTAP   = CI * K_SIZE * K_SIZE;
  localparam int unsigned NW     = CI * CO * K_SIZE * K_SIZE;
  localparam int unsigned PW     = I_BW + W_BW;
  localparam int unsigned AW     = (DEPTH > 1)  ? $clog2(DEPTH)  : 1;
  localparam int unsigned WIW    = (NW > 1)     ? $clog2(NW)     : 1;
  localparam int unsigned KW     = (K_SIZE > 1) ? $clog2(K_SIZE) : 1;
  localparam int unsigned CIW    = (CI > 1)     ? $clog2(CI)     : 1;
  localparam int unsigned COW    = (CO > 1)     ? $clog2(CO)     : 1;
  localparam int unsigned OW     = (O_SIZE > 1) ? $clog2(O_SIZE) : 1;
  localparam int unsigned MW     = $clog2(NTAP + 2);

  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

  state_t            state, state_nxt;
  logic              accept;
  logic [AW-1:0]     ld_cnt;
  logic [AW-1:0]     mem_addr;
  logic [I_BW-1:0]   mem [DEPTH];
  logic [I_BW-1:0]   rd_data;
  logic [W_BW-1:0]   w_arr [NW];
  logic [W_BW-1:0]   w_q;
  logic [WIW-1:0]    w_idx;
  logic [MW-1:0]     mac_cnt;
  logic [KW-1:0]     kc, kr;
  logic [CIW-1:0]    ci_cnt;
  logic [OW-1:0]     ocol, orow;
  logic [COW-1:0]    co_cnt;
  logic              tap_v, tap_first;
  logic              issue, pix_end, ld_last, ch_last, last_pix;
  logic signed [PW-1:0] prod;
  logic [ACC_BW-1:0] prod_ext;
  logic [ACC_BW-1:0] acc;
  logic [O_BW-1:0]   pix_val;

  for (genvar g = 0; g < NW; g++) begin : g_w
    assign w_arr[g] = i_weight[g*W_BW +: W_BW];
  end

  assign ld_last  = (ld_cnt == AW'(DEPTH - 1));
  assign issue    = (state == CALC) && (mac_cnt < MW'(NTAP));
  assign pix_end  = (state == CALC) && (mac_cnt == MW'(NTAP + 1));
  assign ch_last  = (ocol == OW'(O_SIZE - 1)) && (orow == OW'(O_SIZE - 1));
  assign last_pix = ch_last && (co_cnt == COW'(CO - 1));

  // Operand addressing for the current tap of the current output pixel
  always_comb begin
    mem_addr = ld_cnt;
    if (state == CALC)
      mem_addr = AW'((32'(ci_cnt) * I_SIZE + 32'(orow) + 32'(kr)) * I_SIZE + 32'(ocol) + 32'(kc));
    w_idx = WIW'(((32'(co_cnt) * CI + 32'(ci_cnt)) * K_SIZE + 32'(kr)) * K_SIZE + 32'(kc));
  end

  assign prod     = PW'($signed(rd_data)) * PW'($signed(w_q));
  assign prod_ext = ACC_BW'(prod);

  always_comb begin
    pix_val = '0;
`ifdef CONV_LAYER_MC_SAT_EN
    begin
      logic [ACC_BW-1:0] shifted;
      shifted = acc[ACC_BW-1] ? '0 : (acc >> SHIFT);
      pix_val = (shifted > ACC_BW'((64'd1 << (O_BW - 1)) - 64'd1)) ?
                O_BW'((64'd1 << (O_BW - 1)) - 64'd1) : O_BW'(shifted);
    end
`else
    pix_val = acc[ACC_BW-1] ? '0 : acc[SHIFT +: O_BW];
`endif
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    if (rst_processEnd) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (i_valid) begin
          accept    = 1'b1;
          state_nxt = ld_last ? CALC : LOAD;
        end
        LOAD: if (i_valid) begin
          accept = 1'b1;
          if (ld_last) state_nxt = CALC;
        end
        CALC: if (pix_end && last_pix) state_nxt = DONE;
        DONE: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) state <= IDLE;
    else               state <= state_nxt;
  end

  // Frame buffer: single port, no reset, one-cycle read latency
  always_ff @(posedge clk) begin
    if (accept) mem[mem_addr] <= i_fmap;
    rd_data <= mem[mem_addr];
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      o_ready <= 1'b1;  o_busy <= 1'b0;
      o_result <= '0;   o_valid <= 1'b0;  o_ch_end <= 1'b0;  o_allch_end <= 1'b0;
      ld_cnt <= '0;     mac_cnt <= '0;    kc <= '0;  kr <= '0;  ci_cnt <= '0;
      ocol <= '0;       orow <= '0;       co_cnt <= '0;
      tap_v <= 1'b0;    tap_first <= 1'b0;  w_q <= '0;  acc <= '0;
    end else begin
      o_ready     <= (state_nxt == IDLE) || (state_nxt == LOAD);
      o_busy      <= (state_nxt != IDLE);
      o_valid     <= 1'b0;
      o_ch_end    <= 1'b0;
      o_allch_end <= 1'b0;
      if (rst_processEnd) begin
        o_result <= '0;  ld_cnt <= '0;  mac_cnt <= '0;  kc <= '0;  kr <= '0;  ci_cnt <= '0;
        ocol <= '0;      orow <= '0;    co_cnt <= '0;   tap_v <= 1'b0;  tap_first <= 1'b0;
        w_q <= '0;       acc <= '0;
      end else begin
        if (accept) ld_cnt <= ld_last ? '0 : ld_cnt + AW'(1);
        tap_v     <= issue;
        tap_first <= issue && (mac_cnt == '0);
        w_q       <= w_arr[w_idx];
        if (tap_v) acc <= tap_first ? prod_ext : acc + prod_ext;
        if (state == CALC) begin
          mac_cnt <= pix_end ? '0 : mac_cnt + MW'(1);
          // Tap walk: kc fastest, then kr, then ci; wraps to zero after the last tap
          if (issue) begin
            if (kc == KW'(K_SIZE - 1)) begin
              kc <= '0;
              if (kr == KW'(K_SIZE - 1)) begin
                kr     <= '0;
                ci_cnt <= (ci_cnt == CIW'(CI - 1)) ? '0 : ci_cnt + CIW'(1);
              end else kr <= kr + KW'(1);
            end else kc <= kc + KW'(1);
          end
          if (pix_end) begin
            o_result    <= pix_val;
            o_valid     <= 1'b1;
            o_ch_end    <= ch_last;
            o_allch_end <= last_pix;
            if (ocol == OW'(O_SIZE - 1)) begin
              ocol <= '0;
              if (orow == OW'(O_SIZE - 1)) begin
                orow   <= '0;
                co_cnt <= (co_cnt == COW'(CO - 1)) ? '0 : co_cnt + COW'(1);
              end else orow <= orow + OW'(1);
            end else ocol <= ocol + OW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_layer_mc.sv
// Scoreboard bench for conv_layer_mc on a 4x4x2 -> 2x2x2 frame (3x3 kernel), with a 4-bit-output twin.
module tb_conv_layer_mc;

  localparam int unsigned I_SIZE = 4, K_SIZE = 3, CI = 2, CO = 2;
  localparam int unsigned WB = CI * CO * K_SIZE * K_SIZE * 8;
  localparam int NPIX = 32;

  logic clk = 1'b0;
  logic global_rst_n, rst_processEnd, i_valid;
  logic [7:0] i_fmap;
  logic [WB-1:0] i_weight;
  logic o_ready, o_valid, o_ch_end, o_allch_end, o_busy;
  logic [15:0] o_result;
  logic o4_ready, o4_valid, o4_ch_end, o4_allch_end, o4_busy;
  logic [3:0] o4_result;

  always #5 clk = ~clk;

  conv_layer_mc #(.I_SIZE(I_SIZE), .K_SIZE(K_SIZE), .CI(CI), .CO(CO), .I_BW(8), .W_BW(8),
                  .ACC_BW(20), .O_BW(16), .SHIFT(0)) dut (
    .clk(clk), .global_rst_n(global_rst_n), .rst_processEnd(rst_processEnd),
    .i_valid(i_valid), .o_ready(o_ready), .i_fmap(i_fmap), .i_weight(i_weight),
    .o_result(o_result), .o_valid(o_valid), .o_ch_end(o_ch_end),
    .o_allch_end(o_allch_end), .o_busy(o_busy));

  conv_layer_mc #(.I_SIZE(I_SIZE), .K_SIZE(K_SIZE), .CI(CI), .CO(CO), .I_BW(8), .W_BW(8),
                  .ACC_BW(20), .O_BW(4), .SHIFT(0)) dut4 (
    .clk(clk), .global_rst_n(global_rst_n), .rst_processEnd(rst_processEnd),
    .i_valid(i_valid), .o_ready(o4_ready), .i_fmap(i_fmap), .i_weight(i_weight),
    .o_result(o4_result), .o_valid(o4_valid), .o_ch_end(o4_ch_end),
    .o_allch_end(o4_allch_end), .o_busy(o4_busy));

  typedef struct packed { logic [15:0] res; logic ce; logic ae; } exp_t;

  exp_t       q[$];
  logic [3:0] q4[$];
  exp_t       e;
  int checks = 0, failures = 0;
  int cyc = 0, last_pulse_cyc = 0;
  bit spacing_armed = 1'b0;
  int pix[NPIX];
  int ev[8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] exp4(input int v);
`ifdef CONV_LAYER_MC_SAT_EN
    return (v > 7) ? 4'd7 : 4'(v);
`else
    return 4'(v);
`endif
  endfunction

  task automatic push_exp(input int v, input bit ce, input bit ae);
    q.push_back({16'(v), ce, ae});
    q4.push_back(exp4(v));
  endtask

  // Queue a full frame of 8 pixels from ev[]
  task automatic push_frame();
    for (int p = 0; p < 8; p++) push_exp(ev[p], (p == 3) || (p == 7), p == 7);
  endtask

  task automatic set_weights(input int w0, input int w1);
    for (int i = 0; i < CI * CO * K_SIZE * K_SIZE; i++)
      i_weight[i*8 +: 8] = 8'((i < 18) ? w0 : w1);
  endtask

  task automatic load_frame(input bit toggle, input bit hold_valid);
    int idx = 0;
    int n = 0;
    spacing_armed = 1'b0;
    while (idx < NPIX && n < 200) begin
      @(negedge clk);
      i_valid = toggle ? (n % 2 == 0) : 1'b1;
      i_fmap  = 8'(pix[idx]);
      if (i_valid && o_ready) idx++;
      n++;
    end
    check("load_accepted", idx, NPIX);
    @(negedge clk);
    check("ready_low_after_load", o_ready, 0);
    i_valid = hold_valid;
    i_fmap  = 8'h55;
  endtask

  task automatic wait_frame();
    int n = 0;
    while (!o_allch_end && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("frame_end_seen", o_allch_end, 1);
    i_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("queue_drained", q.size() + q4.size(), 0);
    check("idle_busy", o_busy, 0);
    check("idle_ready", o_ready, 1);
  endtask

  always @(negedge clk) begin
    if (global_rst_n) begin
      if (o_valid) begin
        if (q.size() == 0) check("unexpected_pulse", 1, 0);
        else begin
          e = q.pop_front();
          check("result", o_result, e.res);
          check("ch_end", o_ch_end, e.ce);
          check("allch_end", o_allch_end, e.ae);
        end
        if (spacing_armed) check("pulse_spacing", cyc - last_pulse_cyc, 20);
        last_pulse_cyc = cyc;
        spacing_armed  = !o_allch_end;
      end else if (o_ch_end || o_allch_end) begin
        check("strobe_without_valid", 1, 0);
      end
      if (o4_valid) begin
        if (q4.size() == 0) check("unexpected_pulse4", 1, 0);
        else check("result4", o4_result, q4.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    global_rst_n = 1'b0; rst_processEnd = 1'b0; i_valid = 1'b0; i_fmap = '0; i_weight = '0;
    repeat (3) @(negedge clk);
    check("rst_result", o_result, 0);
    check("rst_valid", o_valid, 0);
    check("rst_busy", o_busy, 0);
    global_rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", o_ready, 1);
    check("rst_strobes", {o_valid, o_ch_end, o_allch_end}, 0);

    // All ones, all weights 1: 2 channels x 9 taps -> 18
    for (int i = 0; i < NPIX; i++) pix[i] = 1;
    set_weights(1, 1);
    for (int p = 0; p < 8; p++) ev[p] = 18;
    push_frame(); load_frame(1'b0, 1'b0); wait_frame();

    // Channel 1 weights -1: negative sums clamp to 0
    set_weights(1, -1);
    for (int p = 0; p < 8; p++) ev[p] = (p < 4) ? 18 : 0;
    push_frame(); load_frame(1'b0, 1'b0); wait_frame();

    // Gapped loading
    set_weights(1, 1);
    for (int p = 0; p < 8; p++) ev[p] = 18;
    push_frame(); load_frame(1'b1, 1'b0); wait_frame();

    // Ramp input, single taps: co0 w[0][0][1]=1, co1 w[1][2][2]=2; i_valid held high in CALC
    for (int i = 0; i < NPIX; i++) pix[i] = i;
    i_weight = '0;
    i_weight[1*8 +: 8]  = 8'd1;
    i_weight[35*8 +: 8] = 8'd2;
    ev = '{1, 2, 5, 6, 52, 54, 60, 62};
    push_frame(); load_frame(1'b0, 1'b1); wait_frame();

    // Synchronous abort during the 3rd pixel
    for (int i = 0; i < NPIX; i++) pix[i] = 1;
    set_weights(1, 1);
    push_exp(18, 1'b0, 1'b0); push_exp(18, 1'b0, 1'b0);
    load_frame(1'b0, 1'b0);
    repeat (45) @(negedge clk);
    rst_processEnd = 1'b1;
    i_valid = 1'b1;
    @(negedge clk);
    rst_processEnd = 1'b0;
    i_valid = 1'b0;
    check("abort_valid", o_valid, 0);
    check("abort_busy", o_busy, 0);
    check("abort_ready", o_ready, 1);
    repeat (60) @(negedge clk);
    check("abort_queue", q.size() + q4.size(), 0);
    for (int p = 0; p < 8; p++) ev[p] = 18;
    push_frame(); load_frame(1'b0, 1'b0); wait_frame();

    // Asynchronous reset mid-CALC, after two pulses
    push_exp(18, 1'b0, 1'b0); push_exp(18, 1'b0, 1'b0);
    load_frame(1'b0, 1'b0);
    repeat (45) @(negedge clk);
    check("pre_async_result", o_result, 18);
    #2 global_rst_n = 1'b0;
    #1;
    check("async_result", o_result, 0);
    check("async_result4", o4_result, 0);
    check("async_busy", o_busy, 0);
    check("async_strobes", {o_valid, o_ch_end, o_allch_end}, 0);
    repeat (2) @(negedge clk);
    global_rst_n = 1'b1;
    @(negedge clk);
    check("post_async_ready", o_ready, 1);
    check("post_async_queue", q.size() + q4.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
